// File: rtl/serial_frame_tx_if.sv
// Handshake and data bundle for serial_frame_tx: frame request, payload bytes,
// and the registered serial line / status returned by the transmitter.
interface serial_frame_tx_if;
    logic       LOAD;
    logic       MODE;
    logic [7:0] DIN_A;
    logic [7:0] DIN_B;
    logic [7:0] DIN_C;
    logic       DOUT;
    logic       READY;
    logic       DONE;

    modport master (
        output LOAD, MODE, DIN_A, DIN_B, DIN_C,
        input  DOUT, READY, DONE
    );

    modport slave (
        input  LOAD, MODE, DIN_A, DIN_B, DIN_C,
        output DOUT, READY, DONE
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: all-ones preamble, start bit, 8 or 24
// data bits MSB first, optional even parity; DOUT/READY/DONE are registered.
module serial_frame_tx #(
    parameter int PRE_LEN   = 11,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             CLK_30MHZ,
    input  logic             RST,
    serial_frame_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        START,
        DATA,
        PAR
    } state_t;

    localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);

    state_t      state;
    logic [23:0] shreg;
    logic [4:0]  cnt;
    logic        wide;
    logic        par;

    // State names the bit currently on DOUT; each branch registers the next bit.
    always_ff @(posedge CLK_30MHZ) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            wide      <= 1'b0;
            par       <= 1'b0;
            bus.DOUT  <= 1'b1;
            bus.READY <= 1'b1;
            bus.DONE  <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                IDLE: begin
                    bus.DOUT  <= 1'b1;
                    bus.READY <= 1'b1;
                    if (bus.LOAD) begin
                        state     <= PRE;
                        shreg     <= bus.MODE ? {bus.DIN_A, bus.DIN_B, bus.DIN_C}
                                              : {bus.DIN_A, 16'h0000};
                        wide      <= bus.MODE;
                        par       <= 1'b0;
                        cnt       <= PRE_LAST;
                        bus.READY <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state    <= START;
                        cnt      <= '0;
                        bus.DOUT <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                START: begin
                    state    <= DATA;
                    cnt      <= wide ? 5'd23 : 5'd7;
                    bus.DOUT <= shreg[23];
                    par      <= par ^ shreg[23];
                    shreg    <= {shreg[22:0], 1'b0};
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt      <= cnt - 5'd1;
                        bus.DOUT <= shreg[23];
                        par      <= par ^ shreg[23];
                        shreg    <= {shreg[22:0], 1'b0};
                    end else if (PARITY_EN) begin
                        // par already includes the last data bit, now on DOUT
                        state    <= PAR;
                        cnt      <= '0;
                        bus.DOUT <= par;
                    end else begin
                        state     <= IDLE;
                        cnt       <= '0;
                        bus.DOUT  <= 1'b1;
                        bus.READY <= 1'b1;
                        bus.DONE  <= 1'b1;
                    end
                end
                PAR: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bus.DOUT  <= 1'b1;
                    bus.READY <= 1'b1;
                    bus.DONE  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bus.DOUT  <= 1'b1;
                    bus.READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: two configurations driven in parallel,
// expected per-cycle {DOUT,READY,DONE} built from a frame-level model.
module tb_serial_frame_tx;

    typedef logic [2:0] exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_frame_tx_if bus0 ();
    serial_frame_tx_if bus1 ();

    serial_frame_tx dut0 (
        .CLK_30MHZ(clk),
        .RST      (rst),
        .bus      (bus0)
    );

    serial_frame_tx #(
        .PRE_LEN  (3),
        .PARITY_EN(1'b0)
    ) dut1 (
        .CLK_30MHZ(clk),
        .RST      (rst),
        .bus      (bus1)
    );

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: each accepted frame is a bit string; remaining cycles count down.
    int          m_pre[2] = '{11, 3};
    bit          m_par[2] = '{1'b1, 1'b0};
    int          rem[2]   = '{0, 0};
    int          flen[2]  = '{0, 0};
    logic [63:0] fv[2];

    function automatic exp_t model_step(input int k, input bit r, input bit ld, input bit md,
                                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [23:0] d;
        logic [63:0] f;
        int          n;
        int          len;
        int          pos;
        exp_t        e;
        if (r) begin
            rem[k] = 0;
            return 3'b110;
        end
        if (rem[k] == 0 && ld) begin
            d   = md ? {a, b, c} : {a, 16'h0000};
            n   = md ? 24 : 8;
            f   = '0;
            len = 0;
            for (int i = 0; i < m_pre[k]; i++) begin
                f = {f[62:0], 1'b1};
                len++;
            end
            f = {f[62:0], 1'b0};
            len++;
            for (int i = 0; i < n; i++) begin
                f = {f[62:0], d[23-i]};
                len++;
            end
            if (m_par[k]) begin
                f = {f[62:0], ($countones(d) % 2 == 1)};
                len++;
            end
            fv[k]   = f;
            flen[k] = len;
            rem[k]  = len + 1;
        end
        if (rem[k] > 0) begin
            pos = flen[k] + 1 - rem[k];
            rem[k]--;
            if (pos < flen[k]) e = {fv[k][flen[k]-1-pos], 2'b00};
            else               e = 3'b111;
        end else begin
            e = 3'b110;
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit ld, input bit md,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        rst        = r;
        bus0.LOAD  = ld; bus0.MODE = md; bus0.DIN_A = a; bus0.DIN_B = b; bus0.DIN_C = c;
        bus1.LOAD  = ld; bus1.MODE = md; bus1.DIN_A = a; bus1.DIN_B = b; bus1.DIN_C = c;
        sb0.push_back(model_step(0, r, ld, md, a, b, c));
        sb1.push_back(model_step(1, r, ld, md, a, b, c));
    endtask

    task automatic rstep(input bit r, input bit ld);
        step(r, ld, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic check(input string nm, input exp_t got, input exp_t want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s dout/ready/done got %b want %b at %0t", nm, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                check("cfg_pre11_par", {bus0.DOUT, bus0.READY, bus0.DONE}, e);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check("cfg_pre3_nopar", {bus1.DOUT, bus1.READY, bus1.DONE}, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus0.LOAD = 1'b0; bus0.MODE = 1'b0; bus0.DIN_A = '0; bus0.DIN_B = '0; bus0.DIN_C = '0;
        bus1.LOAD = 1'b0; bus1.MODE = 1'b0; bus1.DIN_A = '0; bus1.DIN_B = '0; bus1.DIN_C = '0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 8'h00);
        repeat (26) rstep(1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        repeat (42) rstep(1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        repeat (26) rstep(1'b0, 1'b0);

        for (int i = 0; i < 70; i++)
            step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (30) rstep(1'b0, 1'b0);

        // Reset lands on data bit 10 of a MODE=1 frame
        step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (22) rstep(1'b0, 1'b0);
        rstep(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (42) rstep(1'b0, 1'b0);

        rstep(1'b1, 1'b1);
        repeat (3) rstep(1'b0, 1'b0);

        for (int i = 0; i < 3000; i++)
            rstep($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0);

        repeat (3) rstep(1'b0, 1'b0);
        @(posedge clk);
        #3;
        n_cmp++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d/%0d want 0/0", sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
